// File: rtl/alu_issue_queue.sv
// Command FIFO and issue controller feeding a combinational 32-bit ALU.
// One command in flight at a time; the result is held in a valid/ready output register.
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_x,
    input  logic [31:0]   in_y,
    input  logic [4:0]    in_z,
    input  logic [2:0]    in_op,
    output logic [31:0]   alu_x,
    output logic [31:0]   alu_y,
    output logic [4:0]    alu_z,
    output logic [2:0]    alu_op,
    input  logic [31:0]   alu_result,
    input  logic          alu_overflow,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_result,
    output logic          out_overflow,
    output logic [2:0]    out_op,
    output logic [AW:0]   count,
    output logic          ovf_sticky,
    input  logic          clr_sticky,
    output logic [15:0]   ops_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [31:0]   mem_x  [DEPTH];
    logic [31:0]   mem_y  [DEPTH];
    logic [4:0]    mem_z  [DEPTH];
    logic [2:0]    mem_op [DEPTH];

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    state_q, state_d;

    logic [31:0]   alu_x_q, alu_y_q;
    logic [4:0]    alu_z_q;
    logic [2:0]    alu_op_q;
    logic [31:0]   out_result_q;
    logic          out_overflow_q;
    logic [2:0]    out_op_q;
    logic          ovf_sticky_q;
    logic [15:0]   ops_done_q;

    logic          push, pop, capture;

    assign in_ready = (count_q < DEPTH_C);
    assign push     = in_valid && in_ready;
    assign capture  = (state_q == S_EXEC);

    // Pop decisions use the registered count, so a same-cycle push into an
    // empty queue is only seen on the following cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: state_d = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array has no reset; stale entries are unreachable because count and pointers are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr_q]  <= in_x;
            mem_y[wr_ptr_q]  <= in_y;
            mem_z[wr_ptr_q]  <= in_z;
            mem_op[wr_ptr_q] <= in_op;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            alu_x_q        <= '0;
            alu_y_q        <= '0;
            alu_z_q        <= '0;
            alu_op_q       <= '0;
            out_result_q   <= '0;
            out_overflow_q <= 1'b0;
            out_op_q       <= '0;
            ovf_sticky_q   <= 1'b0;
            ops_done_q     <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                alu_x_q  <= mem_x[rd_ptr_q];
                alu_y_q  <= mem_y[rd_ptr_q];
                alu_z_q  <= mem_z[rd_ptr_q];
                alu_op_q <= mem_op[rd_ptr_q];
            end
            if (capture) begin
                out_result_q   <= alu_result;
                out_overflow_q <= alu_overflow;
                out_op_q       <= alu_op_q;
                ops_done_q     <= ops_done_q + 16'd1;
            end
            // A capture with overflow wins over a simultaneous clear.
            if (capture && alu_overflow) ovf_sticky_q <= 1'b1;
            else if (clr_sticky)         ovf_sticky_q <= 1'b0;
        end
    end

    assign alu_x        = alu_x_q;
    assign alu_y        = alu_y_q;
    assign alu_z        = alu_z_q;
    assign alu_op       = alu_op_q;
    assign out_valid    = (state_q == S_DONE);
    assign out_result   = out_result_q;
    assign out_overflow = out_overflow_q;
    assign out_op       = out_op_q;
    assign count        = count_q;
    assign ovf_sticky   = ovf_sticky_q;
    assign ops_done     = ops_done_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue with a stub ALU (op 000 = add, others = xor).
// The driver pushes expected results; a negedge monitor pops and compares on each handshake.
module tb_alu_issue_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_x, in_y;
    logic [4:0]    in_z;
    logic [2:0]    in_op;
    logic [31:0]   alu_x, alu_y;
    logic [4:0]    alu_z;
    logic [2:0]    alu_op;
    logic [31:0]   alu_result;
    logic          alu_overflow;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_result;
    logic          out_overflow;
    logic [2:0]    out_op;
    logic [AW:0]   count;
    logic          ovf_sticky;
    logic          clr_sticky;
    logic [15:0]   ops_done;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic [2:0]  op;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;

    alu_issue_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_op(in_op),
        .alu_x(alu_x), .alu_y(alu_y), .alu_z(alu_z), .alu_op(alu_op),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_overflow(out_overflow), .out_op(out_op),
        .count(count), .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky),
        .ops_done(ops_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        alu_result   = alu_x ^ alu_y;
        alu_overflow = 1'b0;
        if (alu_op == 3'b000) begin
            alu_result   = alu_x + alu_y;
            alu_overflow = (alu_x[31] == alu_y[31]) && (alu_result[31] != alu_x[31]);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] x, input logic [31:0] y, input logic [4:0] z,
                        input logic [2:0] op, input logic [31:0] res, input logic ovf);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            n_vec++;
            n_miss++;
            $display("FAIL push_timeout: in_ready still low after %0d cycles", guard);
        end
        in_valid = 1'b1;
        in_x = x; in_y = y; in_z = z; in_op = op;
        exp_q.push_back('{res: res, ovf: ovf, op: op});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic release_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_output: got %h with empty scoreboard", out_result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_result",   out_result,        e.res);
                check("sb_overflow", 32'(out_overflow), 32'(e.ovf));
                check("sb_op",       32'(out_op),       32'(e.op));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_cyc;
        int guard;
        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_z = '0; in_op = '0;
        out_ready = 1'b0; clr_sticky = 1'b0;
        tick(); tick();
        rst = 1'b0;

        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_count",     32'(count),      32'd0);
        check("rst_in_ready",  32'(in_ready),   32'd1);
        check("rst_alu_x",     alu_x,           32'd0);
        check("rst_out_res",   out_result,      32'd0);
        check("rst_ops_done",  32'(ops_done),   32'd0);
        check("rst_sticky",    32'(ovf_sticky), 32'd0);

        // Single command latency
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b10000, 3'b000, 32'hFFFF_FFFE, 1'b0);
        check("lat_count_after_push", 32'(count), 32'd1);
        check("lat_alu_x_not_yet",    alu_x,      32'd0);
        tick();
        check("lat_alu_x",   alu_x,          32'hFFFF_FFFF);
        check("lat_alu_y",   alu_y,          32'hFFFF_FFFF);
        check("lat_alu_z",   32'(alu_z),     32'h10);
        check("lat_valid_0", 32'(out_valid), 32'd0);
        tick();
        check("lat_valid_1", 32'(out_valid), 32'd1);
        check("lat_result",  out_result,     32'hFFFF_FFFE);
        check("lat_ops",     32'(ops_done),  32'd1);
        release_one();
        check("lat_idle", 32'(out_valid), 32'd0);

        // Overflow and sticky flag
        push(32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 3'b000, 32'h8000_0000, 1'b1);
        tick(); tick();
        check("ovf_valid",  32'(out_valid),    32'd1);
        check("ovf_out",    32'(out_overflow), 32'd1);
        check("ovf_sticky", 32'(ovf_sticky),   32'd1);
        release_one();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("ovf_cleared", 32'(ovf_sticky), 32'd0);
        push(32'h8000_0000, 32'h8000_0000, 5'd0, 3'b000, 32'h0000_0000, 1'b1);
        tick();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("ovf_set_wins", 32'(ovf_sticky), 32'd1);
        check("ovf2_valid",   32'(out_valid),  32'd1);
        release_one();

        // Full FIFO with back-pressure
        push(32'h10,        32'h1,         5'd0, 3'b000, 32'h11,        1'b0);
        push(32'h20,        32'h2,         5'd0, 3'b000, 32'h22,        1'b0);
        push(32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'd3, 3'b011, 32'hFFFF_FFFF, 1'b0);
        push(32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 3'b000, 32'h7FFF_FFFF, 1'b1);
        push(32'h30,        32'h3,         5'd7, 3'b110, 32'h33,        1'b0);
        check("full_count",    32'(count),     32'd4);
        check("full_in_ready", 32'(in_ready),  32'd0);
        check("full_valid",    32'(out_valid), 32'd1);
        in_valid = 1'b1; in_x = 32'hDEAD_BEEF; in_y = 32'h1; in_op = 3'b000;
        tick(); tick(); tick();
        check("full_reject_count", 32'(count),  32'd4);
        check("full_hold_result",  out_result,  32'h11);
        check("full_hold_op",      32'(out_op), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            tick();
            guard++;
        end
        out_ready = 1'b0;
        check("full_drained", 32'(exp_q.size()), 32'd0);
        tick();
        check("full_idle", 32'(out_valid), 32'd0);

        // Simultaneous push and pop at count 2, then reset in DONE with 3 queued
        push(32'd1, 32'd1, 5'd0, 3'b000, 32'd2, 1'b0);
        push(32'd2, 32'd2, 5'd0, 3'b000, 32'd4, 1'b0);
        push(32'd3, 32'd3, 5'd0, 3'b000, 32'd6, 1'b0);
        check("sim_count_pre", 32'(count),     32'd2);
        check("sim_valid",     32'(out_valid), 32'd1);
        out_ready = 1'b1;
        push(32'd4, 32'd4, 5'd0, 3'b000, 32'd8, 1'b0);
        out_ready = 1'b0;
        check("sim_count_same", 32'(count), 32'd2);
        push(32'd5, 32'd5, 5'd0, 3'b000, 32'd10, 1'b0);
        check("rstm_count_pre", 32'(count),     32'd3);
        check("rstm_in_done",   32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        check("rstm_valid",    32'(out_valid), 32'd0);
        check("rstm_count",    32'(count),     32'd0);
        check("rstm_alu_x",    alu_x,          32'd0);
        check("rstm_alu_op",   32'(alu_op),    32'd0);
        check("rstm_ops_done", 32'(ops_done),  32'd0);
        check("rstm_in_ready", 32'(in_ready),  32'd1);
        rst = 1'b0;
        check("rstm_discarded", 32'(exp_q.size()), 32'd4);
        exp_q.delete();
        tick();
        check("rstm_stays_idle", 32'(out_valid), 32'd0);

        // Streaming with out_ready held high
        out_ready = 1'b1;
        start_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            push(32'(i), 32'd2, 5'd0, 3'b000, 32'(i + 2), 1'b0);
            if (i == 0) start_cyc = cyc;
            check("stream_count_le_depth", 32'(count <= 3'(DEPTH)), 32'd1);
        end
        guard = 0;
        while (ops_done != 16'd8 && guard < 50) begin
            tick();
            guard++;
        end
        check("stream_cycles", 32'(cyc - start_cyc), 32'd16);
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        check("stream_ops",     32'(ops_done),     32'd8);
        out_ready = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
